// File: rtl/edge_event_pkg.sv
// -----------------------------------------------------------------------------
// edge_event_pkg
//   Shared types and default sizing for the edge event unit.
//   - edge_mode_t  : global edge selection (off / rise / fall / both)
//   - *_DEF        : default channel count, filter width and counter width
//   - edge_qualify : turns raw rise/fall indications into an event bit under
//                    the current mode
// -----------------------------------------------------------------------------
package edge_event_pkg;

    localparam int NCH_DEF    = 8;
    localparam int FILT_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    // An event is a filtered-level change whose direction the mode accepts.
    function automatic logic edge_qualify(
        input edge_mode_t mode,
        input logic       rise,
        input logic       fall
    );
        logic rise_ok;
        logic fall_ok;
        rise_ok = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
        fall_ok = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
        return (rise & rise_ok) | (fall & fall_ok);
    endfunction

endpackage

// File: rtl/edge_event_if.sv
// -----------------------------------------------------------------------------
// edge_event_if
//   Bundles the control inputs and status outputs of the edge event unit.
//   Parameters follow the unit: NCH channels, FILT_W filter width, CNT_W
//   counter width.
//   master modport : the side that drives din/mode/filt_len/strobes and
//                    observes pulse/sticky/evt_cnt (status block, bench)
//   slave modport  : the edge event unit itself
//   Signals:
//     din        [NCH]    raw channel inputs
//     mode       [2]      global edge selection (edge_mode_t)
//     filt_len   [FILT_W] stability requirement F, 0 = unfiltered
//     sticky_clr [NCH]    per-channel sticky clear strobe
//     cnt_clr    [1]      event counter clear strobe
//     pulse      [NCH]    one-cycle event pulses
//     sticky     [NCH]    latched event flags
//     evt_cnt    [CNT_W]  saturating event count
// -----------------------------------------------------------------------------
interface edge_event_if
    import edge_event_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int FILT_W = FILT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    logic [NCH-1:0]    din;
    edge_mode_t        mode;
    logic [FILT_W-1:0] filt_len;
    logic [NCH-1:0]    sticky_clr;
    logic              cnt_clr;
    logic [NCH-1:0]    pulse;
    logic [NCH-1:0]    sticky;
    logic [CNT_W-1:0]  evt_cnt;

    modport master (
        output din,
        output mode,
        output filt_len,
        output sticky_clr,
        output cnt_clr,
        input  pulse,
        input  sticky,
        input  evt_cnt
    );

    modport slave (
        input  din,
        input  mode,
        input  filt_len,
        input  sticky_clr,
        input  cnt_clr,
        output pulse,
        output sticky,
        output evt_cnt
    );

endinterface

// File: rtl/edge_event_chan.sv
// -----------------------------------------------------------------------------
// edge_chan
//   One channel of the edge event unit: optional input synchronizer, glitch
//   filter, filtered level, edge qualification, pulse and sticky flag.
//   Optional feature macro: EDGE_SYNC2_EN (2-flop synchronizer on din, adds
//   two cycles of latency; flops reset to 0).
//   Ports:
//     clk        in   clock, posedge
//     resetn     in   asynchronous active-low reset
//     din        in   raw channel input
//     mode       in   global edge selection
//     filt_len   in   stability requirement F
//     sticky_clr in   sticky clear strobe (a same-cycle event wins)
//     pulse_next out  combinational event, value pulse takes at next posedge
//     pulse      out  registered one-cycle event pulse
//     sticky     out  latched event flag
// -----------------------------------------------------------------------------
module edge_chan
    import edge_event_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              din,
    input  edge_mode_t        mode,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              sticky_clr,
    output logic              pulse_next,
    output logic              pulse,
    output logic              sticky
);

    logic              samp;
    logic              lvl_reg;
    logic              lvl_next;
    logic [FILT_W-1:0] cnt_reg;
    logic [FILT_W-1:0] cnt_next;
    logic              rise;
    logic              fall;
    logic              pulse_reg;
    logic              sticky_reg;
    logic              sticky_next;

`ifdef EDGE_SYNC2_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], din};
        end
    end

    assign samp = sync_reg[1];
`else
    assign samp = din;
`endif

    // Glitch filter: the counter measures how long the sample has disagreed
    // with the filtered level. Once it has reached filt_len, the next
    // disagreeing sample flips the level, i.e. F+1 consecutive samples are
    // needed. filt_len is compared live, so shortening it mid-count can
    // flip the level immediately.
    always_comb begin
        lvl_next = lvl_reg;
        cnt_next = cnt_reg;
        if (samp == lvl_reg) begin
            cnt_next = '0;
        end else if (cnt_reg >= filt_len) begin
            lvl_next = samp;
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + FILT_W'(1);
        end
    end

    assign rise       = lvl_next & ~lvl_reg;
    assign fall       = ~lvl_next & lvl_reg;
    // The level tracks regardless of mode, so switching mode never creates
    // an event by itself.
    assign pulse_next = edge_qualify(mode, rise, fall);

    // Set has priority over clear so an event is never lost to a clear.
    assign sticky_next = (sticky_reg & ~sticky_clr) | pulse_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lvl_reg    <= 1'b0;
            cnt_reg    <= '0;
            pulse_reg  <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            lvl_reg    <= lvl_next;
            cnt_reg    <= cnt_next;
            pulse_reg  <= pulse_next;
            sticky_reg <= sticky_next;
        end
    end

    assign pulse  = pulse_reg;
    assign sticky = sticky_reg;

endmodule

// File: rtl/edge_event_unit.sv
// -----------------------------------------------------------------------------
// edge_event_unit
//   Multi-channel edge detector with per-channel glitch filter, sticky
//   status and a saturating global event counter. Sits between raw GPIO /
//   status lines and the interrupt/status register block.
//   Optional feature macro: EDGE_SYNC2_EN (per-bit 2-flop synchronizer in
//   every channel; without it din must already be synchronous to clk).
//   Parameters: NCH channels, FILT_W filter width, CNT_W counter width.
//   Ports:
//     clk     in     clock, posedge
//     resetn  in     asynchronous active-low reset
//     bus     slave  edge_event_if: din/mode/filt_len/sticky_clr/cnt_clr in,
//                    pulse/sticky/evt_cnt out
// -----------------------------------------------------------------------------
module edge_event_unit
    import edge_event_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int FILT_W = FILT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    edge_event_if.slave  bus
);

    localparam int PC_W  = $clog2(NCH + 1);
    // Wide enough to hold a full counter plus a full popcount.
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    wire  [NCH-1:0]   pulse_next_bits;
    wire  [NCH-1:0]   pulse_bits;
    wire  [NCH-1:0]   sticky_bits;
    logic [PC_W-1:0]  pop_next;
    logic [SUM_W-1:0] sum_next;
    logic [CNT_W-1:0] evt_cnt_reg;
    logic [CNT_W-1:0] evt_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            edge_chan #(
                .FILT_W (FILT_W)
            ) u_chan (
                .clk        (clk),
                .resetn     (resetn),
                .din        (bus.din[gi]),
                .mode       (bus.mode),
                .filt_len   (bus.filt_len),
                .sticky_clr (bus.sticky_clr[gi]),
                .pulse_next (pulse_next_bits[gi]),
                .pulse      (pulse_bits[gi]),
                .sticky     (sticky_bits[gi])
            );
        end
    endgenerate

    // Count the events that will be registered at the coming edge so the
    // counter stays aligned with the pulse outputs.
    always_comb begin
        pop_next = '0;
        for (int i = 0; i < NCH; i++) begin
            pop_next = pop_next + PC_W'(pulse_next_bits[i]);
        end
    end

    // Clear first, then add this cycle's events; clamp instead of wrapping.
    always_comb begin
        sum_next     = (bus.cnt_clr ? '0 : SUM_W'(evt_cnt_reg)) + SUM_W'(pop_next);
        evt_cnt_next = (sum_next > CNT_MAX) ? {CNT_W{1'b1}} : sum_next[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            evt_cnt_reg <= '0;
        end else begin
            evt_cnt_reg <= evt_cnt_next;
        end
    end

    assign bus.pulse   = pulse_bits;
    assign bus.sticky  = sticky_bits;
    assign bus.evt_cnt = evt_cnt_reg;

endmodule

// File: tb/tb_edge_event_unit.sv
// -----------------------------------------------------------------------------
// tb_edge_event_unit
//   Self-checking bench for edge_event_unit. Two instances: the default
//   build (8 ch, F 4 bit, 8-bit counter) and one with a 4-bit counter for
//   saturation. Vectors carry inputs plus hand-derived expected outputs;
//   expectations go into a scoreboard queue when a vector is driven and are
//   popped and compared one clock later.
// -----------------------------------------------------------------------------
module tb_edge_event_unit;
    import edge_event_pkg::*;

    typedef struct {
        bit         sel;      // 0: default instance, 1: 4-bit counter instance
        logic [7:0] din;
        edge_mode_t mode;
        logic [3:0] flen;
        logic [7:0] sclr;
        logic       cclr;
        logic [7:0] exp_pulse;
        logic [7:0] exp_sticky;
        logic [7:0] exp_cnt;
    } vec_t;

    typedef struct {
        string      tag;
        bit         sel;
        logic [7:0] exp_pulse;
        logic [7:0] exp_sticky;
        logic [7:0] exp_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    edge_event_if #(.NCH(8), .FILT_W(4), .CNT_W(8)) bus0 ();
    edge_event_if #(.NCH(8), .FILT_W(4), .CNT_W(4)) bus4 ();

    edge_event_unit #(.NCH(8), .FILT_W(4), .CNT_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    edge_event_unit #(.NCH(8), .FILT_W(4), .CNT_W(4)) dut4 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus4)
    );

    function automatic vec_t mk(bit sel, logic [7:0] din, edge_mode_t mode,
                                logic [3:0] flen, logic [7:0] sclr, logic cclr,
                                logic [7:0] ep, logic [7:0] es, logic [7:0] ec);
        vec_t v;
        v.sel = sel; v.din = din; v.mode = mode; v.flen = flen;
        v.sclr = sclr; v.cclr = cclr;
        v.exp_pulse = ep; v.exp_sticky = es; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic compare(input string tag, input bit sel,
                           input logic [7:0] ep, input logic [7:0] es, input logic [7:0] ec);
        logic [7:0] ap, as, ac;
        if (sel) begin
            ap = bus4.pulse; as = bus4.sticky; ac = {4'b0000, bus4.evt_cnt};
        end else begin
            ap = bus0.pulse; as = bus0.sticky; ac = bus0.evt_cnt;
        end
        n_vec++;
        $display("%s inst%0d pulse=%h sticky=%h evt_cnt=%0d", tag, sel, ap, as, ac);
        if (ap !== ep) begin
            n_err++;
            $display("FAIL %s pulse: got %h expected %h", tag, ap, ep);
        end
        if (as !== es) begin
            n_err++;
            $display("FAIL %s sticky: got %h expected %h", tag, as, es);
        end
        if (ac !== ec) begin
            n_err++;
            $display("FAIL %s evt_cnt: got %0d expected %0d", tag, ac, ec);
        end
    endtask

    // Drive one vector right after a posedge, check it just after the next.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        if (v.sel) begin
            bus4.din = v.din; bus4.mode = v.mode; bus4.filt_len = v.flen;
            bus4.sticky_clr = v.sclr; bus4.cnt_clr = v.cclr;
        end else begin
            bus0.din = v.din; bus0.mode = v.mode; bus0.filt_len = v.flen;
            bus0.sticky_clr = v.sclr; bus0.cnt_clr = v.cclr;
        end
        e.tag = tag; e.sel = v.sel;
        e.exp_pulse = v.exp_pulse; e.exp_sticky = v.exp_sticky; e.exp_cnt = v.exp_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            compare(e.tag, e.sel, e.exp_pulse, e.exp_sticky, e.exp_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        bus0.din = 8'hFF; bus0.mode = EDGE_RISE; bus0.filt_len = 4'd0;
        bus0.sticky_clr = 8'h00; bus0.cnt_clr = 1'b0;
        bus4.din = 8'h00; bus4.mode = EDGE_OFF; bus4.filt_len = 4'd0;
        bus4.sticky_clr = 8'h00; bus4.cnt_clr = 1'b0;

        //              sel din    mode       F  sclr   cc  pulse  sticky cnt
        // all ones held through reset release
        vecs.push_back(mk(0, 8'hFF, EDGE_RISE, 0, 8'h00, 0, 8'hFF, 8'hFF, 8));
        vecs.push_back(mk(0, 8'hFF, EDGE_RISE, 0, 8'h00, 0, 8'h00, 8'hFF, 8));
        vecs.push_back(mk(0, 8'hFF, EDGE_RISE, 0, 8'hFF, 0, 8'h00, 8'h00, 8));
        vecs.push_back(mk(0, 8'hFF, EDGE_RISE, 0, 8'h00, 1, 8'h00, 8'h00, 0));
        // falls ignored in RISE, then single ch0 rise
        vecs.push_back(mk(0, 8'h00, EDGE_RISE, 0, 8'h00, 0, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'h01, EDGE_RISE, 0, 8'h00, 0, 8'h01, 8'h01, 1));
        vecs.push_back(mk(0, 8'h01, EDGE_RISE, 0, 8'h00, 0, 8'h00, 8'h01, 1));
        vecs.push_back(mk(0, 8'h01, EDGE_RISE, 0, 8'h00, 0, 8'h00, 8'h01, 1));
        // FALL: rises silent, all eight fall together
        vecs.push_back(mk(0, 8'hFF, EDGE_FALL, 0, 8'h00, 0, 8'h00, 8'h01, 1));
        vecs.push_back(mk(0, 8'h00, EDGE_FALL, 0, 8'h00, 0, 8'hFF, 8'hFF, 9));
        vecs.push_back(mk(0, 8'h00, EDGE_FALL, 0, 8'h00, 0, 8'h00, 8'hFF, 9));
        // mode changes alone; OFF still tracks the level
        vecs.push_back(mk(0, 8'h00, EDGE_BOTH, 0, 8'h00, 0, 8'h00, 8'hFF, 9));
        vecs.push_back(mk(0, 8'hFF, EDGE_OFF,  0, 8'h00, 0, 8'h00, 8'hFF, 9));
        vecs.push_back(mk(0, 8'hFF, EDGE_RISE, 0, 8'h00, 0, 8'h00, 8'hFF, 9));
        // sticky clear alone, then clear colliding with a new ch2 event
        vecs.push_back(mk(0, 8'hFF, EDGE_RISE, 0, 8'h04, 0, 8'h00, 8'hFB, 9));
        vecs.push_back(mk(0, 8'hFF, EDGE_RISE, 0, 8'h00, 0, 8'h00, 8'hFB, 9));
        vecs.push_back(mk(0, 8'hFB, EDGE_FALL, 0, 8'h04, 0, 8'h04, 8'hFF, 10));
        vecs.push_back(mk(0, 8'hFB, EDGE_FALL, 0, 8'h00, 0, 8'h00, 8'hFF, 10));
        vecs.push_back(mk(0, 8'hFB, EDGE_FALL, 0, 8'h04, 0, 8'h00, 8'hFB, 10));
        // counter clear with two same-cycle events
        vecs.push_back(mk(0, 8'hF8, EDGE_BOTH, 0, 8'h00, 1, 8'h03, 8'hFB, 2));
        vecs.push_back(mk(0, 8'hF8, EDGE_BOTH, 0, 8'h00, 0, 8'h00, 8'hFB, 2));
        vecs.push_back(mk(0, 8'hF8, EDGE_BOTH, 0, 8'hFF, 0, 8'h00, 8'h00, 2));
        // F=3: 2-cycle glitch on ch1 is dropped
        vecs.push_back(mk(0, 8'hFA, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h00, 2));
        vecs.push_back(mk(0, 8'hFA, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h00, 2));
        vecs.push_back(mk(0, 8'hF8, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h00, 2));
        vecs.push_back(mk(0, 8'hF8, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h00, 2));
        // F=3: held high, pulse 3 cycles after the first high sample
        vecs.push_back(mk(0, 8'hFA, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h00, 2));
        vecs.push_back(mk(0, 8'hFA, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h00, 2));
        vecs.push_back(mk(0, 8'hFA, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h00, 2));
        vecs.push_back(mk(0, 8'hFA, EDGE_BOTH, 3, 8'h00, 0, 8'h02, 8'h02, 3));
        vecs.push_back(mk(0, 8'hFA, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h02, 3));
        // filt_len lowered mid-count acts at once on the running counter
        vecs.push_back(mk(0, 8'hF8, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h02, 3));
        vecs.push_back(mk(0, 8'hF8, EDGE_BOTH, 1, 8'h00, 0, 8'h02, 8'h02, 4));
        vecs.push_back(mk(0, 8'hF8, EDGE_BOTH, 0, 8'h00, 0, 8'h00, 8'h02, 4));
        // 4-bit counter: 20 events saturate at 15, then clear + 2 events
        vecs.push_back(mk(1, 8'h0F, EDGE_BOTH, 0, 8'h00, 0, 8'h0F, 8'h0F, 4));
        vecs.push_back(mk(1, 8'h00, EDGE_BOTH, 0, 8'h00, 0, 8'h0F, 8'h0F, 8));
        vecs.push_back(mk(1, 8'h0F, EDGE_BOTH, 0, 8'h00, 0, 8'h0F, 8'h0F, 12));
        vecs.push_back(mk(1, 8'h00, EDGE_BOTH, 0, 8'h00, 0, 8'h0F, 8'h0F, 15));
        vecs.push_back(mk(1, 8'h0F, EDGE_BOTH, 0, 8'h00, 0, 8'h0F, 8'h0F, 15));
        vecs.push_back(mk(1, 8'h0C, EDGE_BOTH, 0, 8'h00, 1, 8'h03, 8'h0F, 2));
        vecs.push_back(mk(1, 8'h0C, EDGE_BOTH, 0, 8'h00, 0, 8'h00, 8'h0F, 2));
        // ch0 starts counting towards a rise (F=3) before a reset hits
        vecs.push_back(mk(0, 8'hF9, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h02, 4));
        vecs.push_back(mk(0, 8'hF9, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h02, 4));

        repeat (3) @(posedge clk);
        #1;
        compare("reset0", 0, 8'h00, 8'h00, 8'h00);
        compare("reset4", 1, 8'h00, 8'h00, 8'h00);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of the ch0 filter count: nothing may fire on
        // assertion, and after release the full F+1 samples are needed again.
        resetn  = 1'b0;
        bus0.din = 8'h01;
        #1;
        compare("midrst_assert", 0, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        compare("midrst_hold", 0, 8'h00, 8'h00, 8'h00);
        resetn = 1'b1;
        apply(mk(0, 8'h01, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h00, 0), "post_rst0");
        apply(mk(0, 8'h01, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h00, 0), "post_rst1");
        apply(mk(0, 8'h01, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h00, 0), "post_rst2");
        apply(mk(0, 8'h01, EDGE_BOTH, 3, 8'h00, 0, 8'h01, 8'h01, 1), "post_rst3");
        apply(mk(0, 8'h01, EDGE_BOTH, 3, 8'h00, 0, 8'h00, 8'h01, 1), "post_rst4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
